// File: rtl/ro_puf.sv
// Auxiliary package only; the top module lives in ro_puf_engine.sv.
// Contains no logic so the bundle has a single top module.
package ro_puf_unused_pkg;
  localparam int unsigned UNUSED = 0;
endpackage

// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF engine.
// Holds the FSM state encoding and the bit positions inside the flags word.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCount,
    StCompare,
    StDone
  } state_e;

  localparam int unsigned FLAG_W        = 3;
  localparam int unsigned FLAG_SAT      = 2;
  localparam int unsigned FLAG_TIE      = 1;
  localparam int unsigned FLAG_SAME_SEL = 0;

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of one asynchronous oscillator input after a 2-flop synchroniser.
// The count saturates at all-ones and is cleared while i_clr is high.
module ro_edge_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ro,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic             w_sat;

  assign w_rise = r_sync[1] & ~r_prev;
  assign w_sat  = &r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_sync <= {r_sync[0], i_ro};
      r_prev <= r_sync[1];
      if (i_clr) begin
        r_count <= '0;
      end else if (i_en && w_rise && !w_sat) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_sat   = w_sat;

endmodule

// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine: for each response bit, selects one oscillator per bank,
// counts edges over a fixed window and records which bank was faster.
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int unsigned NUM_RO     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RESP_BITS  = 8,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned WINDOW_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [$clog2(NUM_RO)-1:0]   chal_a,
  input  logic [$clog2(NUM_RO)-1:0]   chal_b,
  input  logic [NUM_RO-1:0]           ro_a,
  input  logic [NUM_RO-1:0]           ro_b,
  output logic                        ro_en,
  output logic                        busy,
  output logic [RESP_BITS-1:0]        resp,
  output logic                        resp_valid,
  output logic [CNT_W-1:0]            cnt_a,
  output logic [CNT_W-1:0]            cnt_b,
  output logic [CNT_W-1:0]            margin,
  output logic [2:0]                  flags
);

  localparam int unsigned SEL_W   = $clog2(NUM_RO);
  localparam int unsigned IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned CYC_MAX = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [CYC_W-1:0]   r_cyc;
  logic [IDX_W-1:0]   r_idx;
  logic [SEL_W-1:0]   r_chal_a;
  logic [SEL_W-1:0]   r_chal_b;
  logic [SEL_W-1:0]   w_sel_a;
  logic [SEL_W-1:0]   w_sel_b;
  logic               w_ro_a;
  logic               w_ro_b;
  logic [CNT_W-1:0]   w_cnt_a;
  logic [CNT_W-1:0]   w_cnt_b;
  logic [CNT_W-1:0]   w_margin;
  logic               w_sat_a;
  logic               w_sat_b;
  logic               w_clr;
  logic               w_en;
  logic               w_settle_done;
  logic               w_window_done;
  logic               w_last_bit;
  logic [RESP_BITS-1:0] r_resp;
  logic [FLAG_W-1:0]  r_flags;
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  logic [CNT_W-1:0]   r_margin;

  // Index width equals SEL_W, so the sum truncates to a mod-NUM_RO select.
  assign w_sel_a = r_chal_a + SEL_W'(r_idx);
  assign w_sel_b = r_chal_b + SEL_W'(r_idx);
  assign w_ro_a  = ro_a[w_sel_a];
  assign w_ro_b  = ro_b[w_sel_b];

  assign w_clr = (r_state == StSettle);
  assign w_en  = (r_state == StCount);

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_a (
    .clk     (clk),
    .reset   (reset),
    .i_ro    (w_ro_a),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_cnt_a),
    .o_sat   (w_sat_a)
  );

  ro_edge_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_b (
    .clk     (clk),
    .reset   (reset),
    .i_ro    (w_ro_b),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_cnt_b),
    .o_sat   (w_sat_b)
  );

  assign w_margin      = (w_cnt_a > w_cnt_b) ? (w_cnt_a - w_cnt_b) : (w_cnt_b - w_cnt_a);
  assign w_settle_done = (r_cyc == CYC_W'(SETTLE_CYC - 1));
  assign w_window_done = (r_cyc == CYC_W'(WINDOW_CYC - 1));
  assign w_last_bit    = (r_idx == IDX_W'(RESP_BITS - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start) w_state_next = StSettle;
      StSettle:  if (w_settle_done) w_state_next = StCount;
      StCount:   if (w_window_done) w_state_next = StCompare;
      StCompare: w_state_next = w_last_bit ? StDone : StSettle;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Phase timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((w_state_next != r_state) || (r_state == StIdle)) begin
        r_cyc <= '0;
      end else begin
        r_cyc <= r_cyc + CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx    <= '0;
      r_chal_a <= '0;
      r_chal_b <= '0;
      r_resp   <= '0;
      r_flags  <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_margin <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_chal_a <= chal_a;
            r_chal_b <= chal_b;
            r_idx    <= '0;
            r_resp   <= '0;
            r_flags  <= '0;
          end
        end
        StCompare: begin
          r_resp[r_idx] <= (w_cnt_a > w_cnt_b);
          r_cnt_a       <= w_cnt_a;
          r_cnt_b       <= w_cnt_b;
          r_margin      <= w_margin;
          if (w_cnt_a == w_cnt_b)   r_flags[FLAG_TIE]      <= 1'b1;
          if (w_sat_a || w_sat_b)   r_flags[FLAG_SAT]      <= 1'b1;
          if (w_sel_a == w_sel_b)   r_flags[FLAG_SAME_SEL] <= 1'b1;
          if (!w_last_bit) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ro_en      = (r_state == StSettle) || (r_state == StCount);
  assign busy       = (r_state != StIdle);
  assign resp_valid = (r_state == StDone);
  assign resp       = r_resp;
  assign cnt_a      = r_cnt_a;
  assign cnt_b      = r_cnt_b;
  assign margin     = r_margin;
  assign flags      = r_flags;

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed bench for ro_puf_engine: three instances (default, single-bit, 4-bit counter)
// driven by free-running synthetic oscillators, results checked through a scoreboard queue.
module tb_ro_puf_engine;

  typedef struct {
    logic [7:0] resp;
    logic [2:0] flags;
    int         a_lo;
    int         a_hi;
    int         b_lo;
    int         b_hi;
    int         m_lo;
    int         m_hi;
    int         lat;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  int pulses0  = 0;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] start_v;
  logic [2:0] chal_a;
  logic [2:0] chal_b;
  int         mode;

  // Oscillators toggle 3 ns off the 10 ns clock grid so sampling is never racy.
  logic w4 = 1'b0, w6 = 1'b0, w10 = 1'b0, w12 = 1'b0, w14 = 1'b0;

  always #5 clk = ~clk;
  initial begin #3; forever #20 w4  = ~w4;  end
  initial begin #3; forever #30 w6  = ~w6;  end
  initial begin #3; forever #50 w10 = ~w10; end
  initial begin #3; forever #60 w12 = ~w12; end
  initial begin #3; forever #70 w14 = ~w14; end

  logic [7:0] ro_a0, ro_b0, ro_a1, ro_b1, ro_a2, ro_b2;

  always_comb begin
    ro_a0 = '0;
    ro_b0 = '0;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0: begin
          ro_a0[k] = w10;
          ro_b0[k] = (k % 2 == 1) ? w6 : w14;
        end
        1: begin
          ro_a0[k] = w12;
          ro_b0[k] = w12;
        end
        default: begin
          ro_a0[k] = (k == 7) ? w14 : ((k == 0) ? w6 : w10);
          ro_b0[k] = w10;
        end
      endcase
    end
  end

  assign ro_a1 = {4'b0000, w10, 3'b000};
  assign ro_b1 = {2'b00, w14, 5'b00000};
  assign ro_a2 = {8{w4}};
  assign ro_b2 = 8'h00;

  logic        o0_ro_en, o0_busy, o0_valid;
  logic [7:0]  o0_resp;
  logic [15:0] o0_cnt_a, o0_cnt_b, o0_margin;
  logic [2:0]  o0_flags;
  logic        o1_ro_en, o1_busy, o1_valid;
  logic [0:0]  o1_resp;
  logic [15:0] o1_cnt_a, o1_cnt_b, o1_margin;
  logic [2:0]  o1_flags;
  logic        o2_ro_en, o2_busy, o2_valid;
  logic [0:0]  o2_resp;
  logic [3:0]  o2_cnt_a, o2_cnt_b, o2_margin;
  logic [2:0]  o2_flags;

  ro_puf_engine u_dut0 (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start_v[0]),
    .chal_a     (chal_a),
    .chal_b     (chal_b),
    .ro_a       (ro_a0),
    .ro_b       (ro_b0),
    .ro_en      (o0_ro_en),
    .busy       (o0_busy),
    .resp       (o0_resp),
    .resp_valid (o0_valid),
    .cnt_a      (o0_cnt_a),
    .cnt_b      (o0_cnt_b),
    .margin     (o0_margin),
    .flags      (o0_flags)
  );

  ro_puf_engine #(
    .RESP_BITS (1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start_v[1]),
    .chal_a     (chal_a),
    .chal_b     (chal_b),
    .ro_a       (ro_a1),
    .ro_b       (ro_b1),
    .ro_en      (o1_ro_en),
    .busy       (o1_busy),
    .resp       (o1_resp),
    .resp_valid (o1_valid),
    .cnt_a      (o1_cnt_a),
    .cnt_b      (o1_cnt_b),
    .margin     (o1_margin),
    .flags      (o1_flags)
  );

  ro_puf_engine #(
    .CNT_W     (4),
    .RESP_BITS (1)
  ) u_dut2 (
    .clk        (clk),
    .reset      (reset_n),
    .start      (start_v[2]),
    .chal_a     (chal_a),
    .chal_b     (chal_b),
    .ro_a       (ro_a2),
    .ro_b       (ro_b2),
    .ro_en      (o2_ro_en),
    .busy       (o2_busy),
    .resp       (o2_resp),
    .resp_valid (o2_valid),
    .cnt_a      (o2_cnt_a),
    .cnt_b      (o2_cnt_b),
    .margin     (o2_margin),
    .flags      (o2_flags)
  );

  always @(negedge clk) if (o0_valid === 1'b1) pulses0++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    n_checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic get_valid(input int d);
    case (d)
      0:       return o0_valid;
      1:       return o1_valid;
      default: return o2_valid;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return o0_busy;
      1:       return o1_busy;
      default: return o2_busy;
    endcase
  endfunction

  // Drives one challenge, pushes its expectation, waits (bounded) for resp_valid, then compares.
  task automatic run(input string tag, input int d, input logic [2:0] ca, input logic [2:0] cb,
                     input exp_t e, input bit pulse_busy);
    int          n;
    logic        vld;
    logic [7:0]  r;
    logic [2:0]  f;
    logic [15:0] a, b, m;
    exp_t        x;
    chal_a = ca;
    chal_b = cb;
    sb.push_back(e);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    chal_a  = ca + 3'd1;
    chal_b  = cb + 3'd2;
    n   = 1;
    vld = get_valid(d);
    while (!vld && n < 9000) begin
      start_v = '0;
      if (pulse_busy && (n == 100 || n == 4000)) start_v[d] = 1'b1;
      @(posedge clk); #1;
      n++;
      vld = get_valid(d);
    end
    start_v = '0;
    chk({tag, " valid_seen"}, {31'd0, vld}, 32'd1);
    case (d)
      0: begin r = o0_resp; f = o0_flags; a = o0_cnt_a; b = o0_cnt_b; m = o0_margin; end
      1: begin
        r = {7'd0, o1_resp}; f = o1_flags; a = o1_cnt_a; b = o1_cnt_b; m = o1_margin;
      end
      default: begin
        r = {7'd0, o2_resp}; f = o2_flags;
        a = {12'd0, o2_cnt_a}; b = {12'd0, o2_cnt_b}; m = {12'd0, o2_margin};
      end
    endcase
    x = sb.pop_front();
    chk({tag, " latency"}, n, x.lat);
    chk({tag, " resp"}, {24'd0, r}, {24'd0, x.resp});
    chk({tag, " flags"}, {29'd0, f}, {29'd0, x.flags});
    chk_rng({tag, " cnt_a"}, {16'd0, a}, x.a_lo, x.a_hi);
    chk_rng({tag, " cnt_b"}, {16'd0, b}, x.b_lo, x.b_hi);
    chk_rng({tag, " margin"}, {16'd0, m}, x.m_lo, x.m_hi);
    @(posedge clk); #1;
    chk({tag, " valid_one_cycle"}, {31'd0, get_valid(d)}, 32'd0);
    chk({tag, " idle_after"}, {31'd0, get_busy(d)}, 32'd0);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, " ro_en"}, {31'd0, o0_ro_en}, 32'd0);
    chk({tag, " busy"}, {31'd0, o0_busy}, 32'd0);
    chk({tag, " valid"}, {31'd0, o0_valid}, 32'd0);
    chk({tag, " resp"}, {24'd0, o0_resp}, 32'd0);
    chk({tag, " cnt_a"}, {16'd0, o0_cnt_a}, 32'd0);
    chk({tag, " cnt_b"}, {16'd0, o0_cnt_b}, 32'd0);
    chk({tag, " margin"}, {16'd0, o0_margin}, 32'd0);
    chk({tag, " flags"}, {29'd0, o0_flags}, 32'd0);
  endtask

  initial begin
    int base;
    reset_n = 1'b0;
    start_v = '0;
    chal_a  = '0;
    chal_b  = '0;
    mode    = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero0("reset");
    chk("reset dut2 busy", {31'd0, o2_busy}, 32'd0);
    reset_n = 1'b1;

    // Counts over a 1024-cycle window are floor or ceil of 1024/period.
    run("basic", 1, 3'd3, 3'd5, '{8'h01, 3'b000, 102, 103, 73, 74, 28, 30, 1030}, 1'b0);
    run("sat", 2, 3'd0, 3'd1, '{8'h01, 3'b100, 15, 15, 0, 0, 15, 15, 1030}, 1'b0);

    mode = 1;
    run("tie", 0, 3'd1, 3'd2, '{8'h00, 3'b010, 85, 86, 85, 86, 0, 0, 8233}, 1'b0);
    mode = 2;
    run("same_sel", 0, 3'd7, 3'd7, '{8'h02, 3'b011, 102, 103, 102, 103, 0, 0, 8233}, 1'b0);
    mode = 0;
    run("alt", 0, 3'd2, 3'd5, '{8'hAA, 3'b000, 102, 103, 73, 74, 28, 30, 8233}, 1'b0);

    // Abort during the counting window of bit 3, then restart immediately.
    chal_a = 3'd2;
    chal_b = 3'd5;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    repeat (3599) @(posedge clk);
    #1;
    chk("mid busy", {31'd0, o0_busy}, 32'd1);
    chk("mid ro_en", {31'd0, o0_ro_en}, 32'd1);
    chk("mid resp", {24'd0, o0_resp}, 32'h02);
    base = pulses0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_zero0("abort");
    reset_n = 1'b1;
    run("restart", 0, 3'd2, 3'd5, '{8'hAA, 3'b000, 102, 103, 73, 74, 28, 30, 8233}, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("single pulse", pulses0 - base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
